// File: rtl/lif_pkg.sv
// Shared types, default parameters and arithmetic helpers for the LIF neuron.
package lif_pkg;

  typedef enum logic {
    INTEGRATE = 1'b0,
    REFRACT   = 1'b1
  } lif_state_e;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_THRESHOLD      = 200;
  localparam int DEF_LEAK_SHIFT     = 3;
  localparam int DEF_REFRACT_CYCLES = 4;
  localparam int DEF_REST           = 0;
  localparam int DEF_CNT_WIDTH      = 16;

  // Unsigned add that clamps to max_val instead of wrapping.
  // The 33-bit intermediate keeps the carry, so operands up to 32 bits are safe.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/lif_membrane_update.sv
// Combinational membrane update: leak, integrate, saturate, threshold compare.
module lif_membrane_update
  import lif_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic [WIDTH-1:0] membrane,
  input  logic [WIDTH-1:0] current_in,
  output logic [WIDTH-1:0] v_next,
  output logic             fire
);

  localparam logic [WIDTH-1:0] MAX_V = '1;
  localparam logic [WIDTH-1:0] THR_V = WIDTH'(THRESHOLD);

  logic [WIDTH-1:0] leak_raw;
  logic [WIDTH-1:0] leak;
  logic [WIDTH-1:0] decayed;

  // Leak has a floor of 1 for any non-zero membrane so small values decay to 0;
  // the sum is clamped before the compare so a threshold at full scale is reachable.
  always_comb begin
    leak_raw = membrane >> LEAK_SHIFT;
    leak     = leak_raw;
    if (membrane != '0 && leak_raw == '0) leak = WIDTH'(1);
    decayed  = membrane - leak;
    v_next   = WIDTH'(sat_add(32'(decayed), 32'(current_in), 32'(MAX_V)));
    fire     = (v_next >= THR_V);
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with refractory period and spike counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INTEGRATE | accumulating current_in into membrane, firing on threshold
// REFRACT   | membrane held at REST, input ignored, counting down
module lif_neuron
  import lif_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int THRESHOLD      = DEF_THRESHOLD,
  parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
  parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES,
  parameter int REST           = DEF_REST,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     current_in,
  output logic                 spike,
  output logic [WIDTH-1:0]     membrane,
  output logic                 refractory,
  output logic [CNT_WIDTH-1:0] spike_count
);

  localparam int RC_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(REFRACT_CYCLES);
  localparam logic [WIDTH-1:0] REST_V  = WIDTH'(REST);

  lif_state_e           state_q, state_d;
  logic [RC_W-1:0]      rc_q, rc_d;
  logic [WIDTH-1:0]     mem_d;
  logic                 spike_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0]     v_next;
  logic                 fire;

  lif_membrane_update #(
    .WIDTH      (WIDTH),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .membrane   (membrane),
    .current_in (current_in),
    .v_next     (v_next),
    .fire       (fire)
  );

  assign refractory = (state_q == REFRACT);

  // State, counters, membrane and spike registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INTEGRATE;
      rc_q        <= '0;
      membrane    <= REST_V;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      membrane    <= mem_d;
      spike       <= spike_d;
      spike_count <= cnt_d;
    end
  end

  // Next-state logic; spike defaults low so it never stretches across a stall.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    mem_d   = membrane;
    spike_d = 1'b0;
    cnt_d   = spike_count;
    if (en) begin
      unique case (state_q)
        INTEGRATE: begin
          if (fire) begin
            spike_d = 1'b1;
            mem_d   = REST_V;
            cnt_d   = spike_count + 1'b1;
            if (REFRACT_CYCLES > 0) begin
              state_d = REFRACT;
              rc_d    = RC_LOAD;
            end
          end else begin
            mem_d = v_next;
          end
        end
        REFRACT: begin
          mem_d = REST_V;
          rc_d  = rc_q - 1'b1;
          // <= rather than == so a corrupted zero count cannot lock the neuron
          if (rc_q <= RC_W'(1)) state_d = INTEGRATE;
        end
        default: state_d = INTEGRATE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed, table-driven bench for lif_neuron across three configurations.
module tb_lif_neuron;

  logic clk;

  // default configuration
  logic        reset_a, en_a;
  logic [7:0]  cur_a, mem_a;
  logic        spike_a, refr_a;
  logic [15:0] cnt_a;

  // THRESHOLD = 255
  logic        reset_s, en_s;
  logic [7:0]  cur_s, mem_s;
  logic        spike_s, refr_s;
  logic [15:0] cnt_s;

  // REFRACT_CYCLES = 0
  logic        reset_n, en_n;
  logic [7:0]  cur_n, mem_n;
  logic        spike_n, refr_n;
  logic [15:0] cnt_n;

  int passed = 0;
  int total  = 0;

  lif_neuron u_dut (
    .clk(clk), .reset(reset_a), .en(en_a), .current_in(cur_a),
    .spike(spike_a), .membrane(mem_a), .refractory(refr_a), .spike_count(cnt_a)
  );

  lif_neuron #(.THRESHOLD(255)) u_sat (
    .clk(clk), .reset(reset_s), .en(en_s), .current_in(cur_s),
    .spike(spike_s), .membrane(mem_s), .refractory(refr_s), .spike_count(cnt_s)
  );

  lif_neuron #(.REFRACT_CYCLES(0)) u_norf (
    .clk(clk), .reset(reset_n), .en(en_n), .current_in(cur_n),
    .spike(spike_n), .membrane(mem_n), .refractory(refr_n), .spike_count(cnt_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic [7:0]  cur;
    logic        sp;
    logic [7:0]  mem;
    logic        refr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int e, input int c, input int sp, input int m,
                     input int r, input int n);
    vec_t t;
    t.en   = 1'(e);
    t.cur  = 8'(c);
    t.sp   = 1'(sp);
    t.mem  = 8'(m);
    t.refr = 1'(r);
    t.cnt  = 16'(n);
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  // inputs change 1 time unit after the rising edge, outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int sp, input int m, input int r, input int n);
    chk({tag, "_spike"},      int'(spike_a), sp);
    chk({tag, "_membrane"},   int'(mem_a),   m);
    chk({tag, "_refractory"}, int'(refr_a),  r);
    chk({tag, "_count"},      int'(cnt_a),   n);
  endtask

  int decay_hand [21] = '{173, 152, 133, 117, 103, 91, 80, 70, 62, 55, 49,
                          43, 38, 34, 30, 27, 24, 21, 19, 17, 15};

  initial begin
    int bad;
    reset_a = 1'b1; en_a = 1'b0; cur_a = '0;
    reset_s = 1'b1; en_s = 1'b0; cur_s = '0;
    reset_n = 1'b1; en_n = 1'b0; cur_n = '0;

    // constant current 50, stalls mid-integration and mid-refractory,
    // a stall right after a spike, input ignored while refractory
    for (int i = 0; i < 5; i++) add(1, 50, 0, (i == 0) ? 50 : (i == 1) ? 94 : (i == 2) ? 133 : (i == 3) ? 167 : 197, 0, 0);
    add(1, 50, 1, 0, 1, 1);
    add(1, 50, 0, 0, 1, 1);
    add(1, 50, 0, 0, 1, 1);
    add(1, 50, 0, 0, 1, 1);
    add(1, 50, 0, 0, 0, 1);
    add(1, 50, 0, 50, 0, 1);
    add(1, 50, 0, 94, 0, 1);
    add(1, 50, 0, 133, 0, 1);
    add(0, 50, 0, 133, 0, 1);
    add(0, 50, 0, 133, 0, 1);
    add(0, 50, 0, 133, 0, 1);
    add(1, 50, 0, 167, 0, 1);
    add(1, 50, 0, 197, 0, 1);
    add(1, 50, 1, 0, 1, 2);
    add(1, 50, 0, 0, 1, 2);
    add(0, 50, 0, 0, 1, 2);
    add(0, 50, 0, 0, 1, 2);
    add(0, 50, 0, 0, 1, 2);
    add(1, 50, 0, 0, 1, 2);
    add(1, 50, 0, 0, 1, 2);
    add(1, 50, 0, 0, 0, 2);
    add(1, 50, 0, 50, 0, 2);
    add(1, 50, 0, 94, 0, 2);
    add(1, 50, 0, 133, 0, 2);
    add(1, 50, 0, 167, 0, 2);
    add(1, 50, 0, 197, 0, 2);
    add(1, 50, 1, 0, 1, 3);
    add(0, 50, 0, 0, 1, 3);
    add(1, 50, 0, 0, 1, 3);
    add(1, 255, 0, 0, 1, 3);
    add(1, 255, 0, 0, 1, 3);
    add(1, 255, 0, 0, 0, 3);
    add(1, 255, 1, 0, 1, 4);

    tick();
    tick();
    chk_a("reset", 0, 0, 0, 0);
    reset_a = 1'b0;

    foreach (vecs[i]) begin
      en_a  = vecs[i].en;
      cur_a = vecs[i].cur;
      tick();
      chk_a($sformatf("vec%0d", i), int'(vecs[i].sp), int'(vecs[i].mem),
            int'(vecs[i].refr), int'(vecs[i].cnt));
    end

    // asynchronous reset while spike is high and refractory is running
    #2;
    reset_a = 1'b1;
    #1;
    chk_a("async_reset", 0, 0, 0, 0);
    tick();
    reset_a = 1'b0;
    en_a = 1'b1; cur_a = 8'd0;
    tick();
    chk_a("reset_release", 0, 0, 0, 0);

    // decay: charge to 197 then let it leak away
    cur_a = 8'd50;
    for (int i = 0; i < 5; i++) tick();
    chk("decay_charge", int'(mem_a), 197);
    cur_a = 8'd0;
    bad = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      chk($sformatf("decay_hand%0d", i), int'(mem_a), decay_hand[i]);
      if (spike_a !== 1'b0) bad++;
    end
    for (int k = 14; k >= 0; k--) begin
      tick();
      chk($sformatf("decay_unit%0d", k), int'(mem_a), k);
      if (spike_a !== 1'b0) bad++;
    end
    tick();
    tick();
    chk("decay_settled", int'(mem_a), 0);
    chk("decay_no_spike", bad, 0);
    chk("decay_count", int'(cnt_a), 0);
    en_a = 1'b0;

    // saturation with threshold at full scale
    reset_s = 1'b0;
    en_s = 1'b1; cur_s = 8'd250;
    tick();
    chk("sat_charge_mem", int'(mem_s), 250);
    chk("sat_charge_spike", int'(spike_s), 0);
    cur_s = 8'd255;
    tick();
    chk("sat_fire_spike", int'(spike_s), 1);
    chk("sat_fire_mem", int'(mem_s), 0);
    chk("sat_fire_count", int'(cnt_s), 1);
    cur_s = 8'd0;
    for (int i = 0; i < 4; i++) tick();
    chk("sat_refr_done", int'(refr_s), 0);
    cur_s = 8'd254;
    tick();
    chk("sat_below_spike", int'(spike_s), 0);
    chk("sat_below_mem", int'(mem_s), 254);
    reset_s = 1'b1;
    tick();
    reset_s = 1'b0;
    cur_s = 8'd255;
    tick();
    chk("sat_exact_spike", int'(spike_s), 1);
    chk("sat_exact_count", int'(cnt_s), 1);
    en_s = 1'b0;

    // no refractory period: fires every enabled cycle, counter wraps
    reset_n = 1'b0;
    en_n = 1'b1; cur_n = 8'd255;
    tick();
    chk("norf_first_spike", int'(spike_n), 1);
    chk("norf_first_mem", int'(mem_n), 0);
    chk("norf_first_refr", int'(refr_n), 0);
    chk("norf_first_count", int'(cnt_n), 1);
    tick();
    chk("norf_second_spike", int'(spike_n), 1);
    chk("norf_second_count", int'(cnt_n), 2);
    bad = 0;
    for (int i = 2; i < 65535; i++) begin
      tick();
      if (spike_n !== 1'b1 || refr_n !== 1'b0) bad++;
    end
    chk("norf_run_pulses", bad, 0);
    chk("norf_count_max", int'(cnt_n), 65535);
    tick();
    chk("norf_wrap_count", int'(cnt_n), 0);
    chk("norf_wrap_spike", int'(spike_n), 1);
    en_n = 1'b0;
    tick();
    chk("norf_stall_spike", int'(spike_n), 0);
    chk("norf_stall_count", int'(cnt_n), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
